// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states,
// control-output bundle and the load-use hazard compare.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        IMEM_WAIT = 2'b01,
        FLUSH     = 2'b10,
        HALT      = 2'b11
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_t;

    //                                    pc   ifid flush bubble
    localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_WAIT   = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_HALT   = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Register specifiers are zero-extended by the caller; r0 never hazards.
    function automatic logic load_use_hit(input logic        memread,
                                          input logic [31:0] ex_rt,
                                          input logic [31:0] rs,
                                          input logic [31:0] rt);
        return memread && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, instruction-memory waits, external halt and perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W          = 5,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam int unsigned FCNT_W       = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
    localparam logic [FCNT_W-1:0] PEN_M1 = FCNT_W'(BRANCH_PENALTY - 1);
    localparam logic LONG_PENALTY        = (BRANCH_PENALTY > 1);

    state_t            state, state_next;
    logic [FCNT_W-1:0] fcnt, fcnt_next;
    logic              load_use;
    ctrl_t             ctrl;

    assign load_use = load_use_hit(id_ex_memread, 32'(id_ex_rt), 32'(id_rs), 32'(id_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        if (halt_req) begin
            state_next = HALT;
            fcnt_next  = '0;
        end else begin
            unique case (state)
                HALT: state_next = RUN;
                FLUSH: begin
                    if (ex_branch_taken)
                        fcnt_next = PEN_M1;
                    else if (fcnt <= FCNT_W'(1)) begin
                        state_next = RUN;
                        fcnt_next  = '0;
                    end else
                        fcnt_next = fcnt - 1'b1;
                end
                default: begin
                    if (ex_branch_taken) begin
                        state_next = LONG_PENALTY ? FLUSH : RUN;
                        fcnt_next  = LONG_PENALTY ? PEN_M1 : '0;
                    end else if (load_use)
                        state_next = (state == IMEM_WAIT && !imem_ready) ? IMEM_WAIT : RUN;
                    else if (!imem_ready)
                        state_next = IMEM_WAIT;
                    else
                        state_next = RUN;
                end
            endcase
        end
    end

    // Branches outrank FLUSH so a branch while flushing also bubbles ID/EX.
    always_comb begin
        ctrl   = CTRL_RUN;
        halted = 1'b0;
        if (rst)
            ctrl = CTRL_RESET;
        else if (state == HALT || halt_req) begin
            ctrl   = CTRL_HALT;
            halted = (state == HALT);
        end else if (ex_branch_taken)
            ctrl = CTRL_BRANCH;
        else if (state == FLUSH)
            ctrl = CTRL_FLUSH;
        else if (load_use)
            ctrl = CTRL_STALL;
        else if (!imem_ready)
            ctrl = CTRL_WAIT;
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!ctrl.pc_write),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.if_id_flush),
        .q   (flush_cycles)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a BRANCH_PENALTY=3 instance and a
// BRANCH_PENALTY=1 / CNT_W=4 instance share one stimulus stream.
module tb_pipeline_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, id_ex_rt;
    logic       id_ex_memread, ex_branch_taken, imem_ready, halt_req;

    logic        d_pc, d_ifid, d_flush, d_bub, d_halt;
    logic [15:0] d_stall, d_fcnt;
    logic        s_pc, s_ifid, s_flush, s_bub, s_halt;
    logic [3:0]  s_stall, s_fcnt;

    int checks = 0;
    int failures = 0;

    pipeline_ctrl #(.REG_W(5), .BRANCH_PENALTY(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready), .halt_req(halt_req),
        .pc_write(d_pc), .if_id_write(d_ifid), .if_id_flush(d_flush),
        .id_ex_bubble(d_bub), .halted(d_halt),
        .stall_cycles(d_stall), .flush_cycles(d_fcnt)
    );

    pipeline_ctrl #(.REG_W(5), .BRANCH_PENALTY(1), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready), .halt_req(halt_req),
        .pc_write(s_pc), .if_id_write(s_ifid), .if_id_flush(s_flush),
        .id_ex_bubble(s_bub), .halted(s_halt),
        .stall_cycles(s_stall), .flush_cycles(s_fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_ex_rt = '0;
        id_ex_memread = 1'b0; ex_branch_taken = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1;
        idle_inputs();

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        chk("rst_pc", 32'(d_pc), 0);       chk("rst_ifid", 32'(d_ifid), 0);
        chk("rst_flush", 32'(d_flush), 1); chk("rst_bub", 32'(d_bub), 1);
        chk("rst_halt", 32'(d_halt), 0);   chk("rst_stall", 32'(d_stall), 0);
        chk("rst_fcnt", 32'(d_fcnt), 0);

        // Free running
        @(negedge clk); rst = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("run_pc", 32'(d_pc), 1); chk("run_ifid", 32'(d_ifid), 1);
            chk("run_flush", 32'(d_flush), 0);
            @(negedge clk); #1;
        end
        chk("run_stall_cnt", 32'(d_stall), 0); chk("run_fcnt", 32'(d_fcnt), 0);

        // Load-use on rs
        id_ex_memread = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5; #1;
        chk("lu_pc", 32'(d_pc), 0); chk("lu_ifid", 32'(d_ifid), 0);
        chk("lu_bub", 32'(d_bub), 1); chk("lu_flush", 32'(d_flush), 0);

        // r0 destination never hazards
        @(negedge clk); id_ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
        chk("r0_pc", 32'(d_pc), 1); chk("r0_bub", 32'(d_bub), 0);
        chk("lu_stall_cnt", 32'(d_stall), 1);

        // Load-use on rt
        @(negedge clk); id_ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; #1;
        chk("lurt_pc", 32'(d_pc), 0);
        @(negedge clk); idle_inputs(); #1;
        chk("lurt_stall_cnt", 32'(d_stall), 2); chk("s_lurt_stall_cnt", 32'(s_stall), 2);

        // Taken branch with a simultaneous load-use that must be ignored
        @(negedge clk); ex_branch_taken = 1'b1;
        id_ex_memread = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7; #1;
        chk("br_pc", 32'(d_pc), 1); chk("br_flush", 32'(d_flush), 1);
        chk("br_bub", 32'(d_bub), 1); chk("s_br_flush", 32'(s_flush), 1);
        @(negedge clk); idle_inputs(); #1;
        chk("fl1_flush", 32'(d_flush), 1); chk("fl1_pc", 32'(d_pc), 1);
        chk("fl1_ifid", 32'(d_ifid), 1);   chk("fl1_bub", 32'(d_bub), 0);
        chk("s_fl1_flush", 32'(s_flush), 0); chk("s_fl1_pc", 32'(s_pc), 1);
        @(negedge clk); #1;
        chk("fl2_flush", 32'(d_flush), 1);
        @(negedge clk); #1;
        chk("fl3_flush", 32'(d_flush), 0); chk("fl3_pc", 32'(d_pc), 1);
        chk("br_fcnt", 32'(d_fcnt), 3);    chk("s_br_fcnt", 32'(s_fcnt), 1);
        chk("br_stall_cnt", 32'(d_stall), 2);

        // imem wait interleaved with a load-use and a branch
        @(negedge clk); imem_ready = 1'b0; #1;
        chk("w0_pc", 32'(d_pc), 0); chk("w0_flush", 32'(d_flush), 1);
        chk("s_w0_pc", 32'(s_pc), 0);
        @(negedge clk); id_ex_memread = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5; #1;
        chk("w1_pc", 32'(d_pc), 0); chk("w1_bub", 32'(d_bub), 1);
        @(negedge clk); ex_branch_taken = 1'b1; #1;
        chk("w2_pc", 32'(d_pc), 1); chk("w2_flush", 32'(d_flush), 1);
        chk("w2_bub", 32'(d_bub), 1); chk("s_w2_pc", 32'(s_pc), 1);
        @(negedge clk); idle_inputs(); #1;
        chk("w3_pc", 32'(d_pc), 1); chk("w3_flush", 32'(d_flush), 1);
        chk("s_w3_pc", 32'(s_pc), 0); chk("s_w3_flush", 32'(s_flush), 1);
        @(negedge clk); imem_ready = 1'b1; #1;
        chk("w4_pc", 32'(d_pc), 1); chk("w4_flush", 32'(d_flush), 1);
        chk("s_w4_pc", 32'(s_pc), 1); chk("s_w4_flush", 32'(s_flush), 0);
        @(negedge clk); #1;
        chk("w5_flush", 32'(d_flush), 0); chk("w5_pc", 32'(d_pc), 1);
        chk("w_stall_cnt", 32'(d_stall), 4); chk("s_w_stall_cnt", 32'(s_stall), 5);

        // Halt from RUN and exit
        @(negedge clk); halt_req = 1'b1; #1;
        chk("h0_halt", 32'(d_halt), 0);
        @(negedge clk); #1;
        chk("h1_halt", 32'(d_halt), 1); chk("h1_pc", 32'(d_pc), 0);
        chk("h1_ifid", 32'(d_ifid), 0); chk("h1_bub", 32'(d_bub), 1);
        @(negedge clk); halt_req = 1'b0; #1;
        chk("h2_halt", 32'(d_halt), 1);
        @(negedge clk); #1;
        chk("h3_halt", 32'(d_halt), 0); chk("h3_pc", 32'(d_pc), 1);

        // Halt during FLUSH, then asynchronous reset while halted
        @(negedge clk); ex_branch_taken = 1'b1; #1;
        @(negedge clk); ex_branch_taken = 1'b0; halt_req = 1'b1; #1;
        chk("hf0_halt", 32'(d_halt), 0);
        @(negedge clk); #1;
        chk("hf1_halt", 32'(d_halt), 1); chk("hf1_pc", 32'(d_pc), 0);
        #2 rst = 1'b1; #1;
        chk("arst_halt", 32'(d_halt), 0);   chk("arst_stall", 32'(d_stall), 0);
        chk("arst_fcnt", 32'(d_fcnt), 0);   chk("arst_pc", 32'(d_pc), 0);
        chk("arst_flush", 32'(d_flush), 1); chk("s_arst_stall", 32'(s_stall), 0);
        @(negedge clk); rst = 1'b0; halt_req = 1'b0; #1;
        chk("post_rst_pc", 32'(d_pc), 1); chk("post_rst_flush", 32'(d_flush), 0);
        chk("post_rst_halt", 32'(d_halt), 0);

        // 20-cycle stall saturates the 4-bit counter
        @(negedge clk); id_ex_memread = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
        repeat (20) @(negedge clk);
        #1;
        chk("sat_d_stall", 32'(d_stall), 20); chk("sat_s_stall", 32'(s_stall), 15);
        chk("sat_fcnt", 32'(d_fcnt), 0);
        @(negedge clk); #1;
        chk("sat_d_stall2", 32'(d_stall), 21); chk("sat_s_stall2", 32'(s_stall), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
